// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU: owns PC/IR, steps
// FETCH/DECODE/EXEC/MEM/WB and drives regfile, ALU, flag and memory-bus controls.
//
// state  | meaning
// FETCH  | read instruction at pc; request held until mem_ready
// DECODE | fields presented to datapath; illegal opcode/cond -> TRAP
// EXEC   | ALU result latched, branch resolved or load/store address formed
// MEM    | data read/write on the bus; held until mem_ready
// WB     | one-cycle regfile write of latched result
// TRAP   | halted, bus and strobes idle until reset
module cpu_control_fsm #(
    parameter int            DW       = 16,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    rf_ra,
    output logic [2:0]    rf_rb,
    input  logic [DW-1:0] rf_rdata_b,
    output logic [2:0]    rf_wa,
    output logic          rf_we,
    output logic [DW-1:0] rf_wdata,
    output logic [3:0]    alu_op,
    output logic          alu_bsel,
    output logic [DW-1:0] imm,
    input  logic [DW-1:0] alu_result,
    input  logic          flag_z,
    input  logic          flag_n,
    output logic          fr_we,
    output logic [DW-1:0] pc,
    output logic [DW-1:0] ir,
    output logic          halted
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    localparam logic [4:0] OP_ADDI = 5'h07;
    localparam logic [4:0] OP_SUBI = 5'h08;
    localparam logic [4:0] OP_SRI  = 5'h0D;
    localparam logic [4:0] OP_BRI  = 5'h0E;
    localparam logic [4:0] OP_GT   = 5'h0F;
    localparam logic [4:0] OP_EQ   = 5'h11;
    localparam logic [4:0] OP_STW  = 5'h12;
    localparam logic [4:0] OP_LDW  = 5'h13;
    localparam logic [4:0] OP_ILL  = 5'h14;

    state_t        state, state_n;
    logic [DW-1:0] wb_data, addr_q, wdata_q;
    logic          fetch_pend;

    logic [4:0]    opcode;
    logic          is_itype, is_cmp, is_bri, is_stw, is_ldw, illegal, br_taken;

    always_comb begin
        opcode   = ir[15:11];
        is_itype = (opcode >= OP_ADDI) && (opcode <= OP_SRI);
        is_cmp   = (opcode >= OP_GT) && (opcode <= OP_EQ);
        is_bri   = (opcode == OP_BRI);
        is_stw   = (opcode == OP_STW);
        is_ldw   = (opcode == OP_LDW);
        illegal  = (opcode >= OP_ILL) || (is_bri && (ir[10:8] >= 3'd5));

        // Fields are presented continuously so the ALU result is valid in EXEC.
        rf_ra    = ir[7:5];
        rf_rb    = is_stw ? ir[10:8] : ir[4:2];
        alu_bsel = is_itype || is_stw || is_ldw;
        alu_op   = opcode[3:0];
        if (is_itype)
            alu_op = opcode[3:0] - 4'd7;
        else if (is_cmp)
            alu_op = opcode[3:0] - 4'd8;
        else if (is_stw || is_ldw || is_bri)
            alu_op = 4'd0;

        imm = '0;
        if (is_bri)
            imm = {{(DW-8){ir[7]}}, ir[7:0]};
        else if (is_stw || is_ldw || opcode == OP_ADDI || opcode == OP_SUBI)
            imm = {{(DW-5){ir[4]}}, ir[4:0]};
        else if (is_itype)
            imm = {{(DW-5){1'b0}}, ir[4:0]};
    end

    always_comb begin
        br_taken = 1'b0;
        case (ir[10:8])
            3'd0:    br_taken = 1'b1;
            3'd1:    br_taken = flag_z;
            3'd2:    br_taken = !flag_z;
            3'd3:    br_taken = flag_n;
            3'd4:    br_taken = !flag_n;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = wdata_q;
        rf_we     = 1'b0;
        rf_wa     = ir[10:8];
        rf_wdata  = wb_data;
        fr_we     = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH: begin
                // A started fetch is held even if run drops.
                if (run || fetch_pend) begin
                    mem_req = 1'b1;
                    if (mem_ready) state_n = S_DECODE;
                end
            end
            S_DECODE: state_n = illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (is_bri)
                    state_n = S_FETCH;
                else if (is_stw || is_ldw)
                    state_n = S_MEM;
                else begin
                    fr_we   = 1'b1;
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_stw;
                mem_addr = addr_q;
                if (mem_ready) state_n = is_ldw ? S_WB : S_FETCH;
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_n = S_FETCH;
            end
            S_TRAP:  halted = 1'b1;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            wb_data    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fetch_pend <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_FETCH: begin
                    if (mem_req) begin
                        if (mem_ready) begin
                            ir         <= mem_rdata;
                            pc         <= pc + DW'(1);
                            fetch_pend <= 1'b0;
                        end else begin
                            fetch_pend <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (is_bri) begin
                        if (br_taken) pc <= pc + imm;
                    end else if (is_stw || is_ldw) begin
                        addr_q  <= alu_result;
                        wdata_q <= rf_rdata_b;
                    end else begin
                        wb_data <= alu_result;
                    end
                end
                S_MEM: begin
                    if (mem_ready && is_ldw) wb_data <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
